// File: rtl/elevator_scheduler.sv
// SCAN scheduler for a single elevator car: latches hall/car requests, picks a
// travel direction, steps the car one floor per TRAVEL_TICKS and times the door dwell.
module elevator_scheduler #(
  parameter int FLOOR        = 6,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic [FLOOR-1:0] btn_up,
  input  logic [FLOOR-1:0] btn_down,
  input  logic [FLOOR-1:0] btn_inside,
  output logic [FLOOR-1:0] current_floor,
  output logic [1:0]       dir,
  output logic             door_open,
  output logic [FLOOR-1:0] pend_up,
  output logic [FLOOR-1:0] pend_down,
  output logic [FLOOR-1:0] pend_inside
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;

  localparam logic [1:0]       LD_NONE  = 2'b00;
  localparam logic [1:0]       LD_UP    = 2'b01;
  localparam logic [1:0]       LD_DOWN  = 2'b10;
  localparam logic [FLOOR-1:0] BOT      = {{(FLOOR-1){1'b0}}, 1'b1};
  localparam logic [FLOOR-1:0] TOP      = {1'b1, {(FLOOR-1){1'b0}}};
  localparam logic [3:0]       TRAV_LIM = 4'(TRAVEL_TICKS);
  localparam logic [3:0]       DOOR_LIM = 4'(DOOR_TICKS);

  state_t           state_q, state_d;
  logic [FLOOR-1:0] floor_q, floor_d;
  logic [3:0]       trav_q, trav_d;
  logic [3:0]       dwell_q, dwell_d;
  logic [1:0]       last_q, last_d;
  logic [FLOOR-1:0] pu_q, pd_q, pi_q;
  logic [FLOOR-1:0] clr_up, clr_dn, clr_in;

  // Current-floor view of the request map.
  logic [FLOOR-1:0] req, below_m, above_m;
  logic             any_here, any_above, any_below;

  assign req       = pu_q | pd_q | pi_q;
  assign below_m   = floor_q - BOT;
  assign above_m   = ~(floor_q | below_m);
  assign any_here  = |(req & floor_q);
  assign any_above = |(req & above_m);
  assign any_below = |(req & below_m);

  // Arrival view: the floor the car reaches on this tick and what lies beyond it.
  logic             going_up;
  logic [FLOOR-1:0] nf, nf_below, nf_above, same_m, opp_m;
  logic             ahead, at_end, hit_in, hit_same, hit_opp, stop;
  logic [3:0]       trav_inc, dwell_inc;

  assign going_up  = (state_q == S_UP);
  assign nf        = going_up ? ((floor_q == TOP) ? floor_q : floor_q << 1)
                              : ((floor_q == BOT) ? floor_q : floor_q >> 1);
  assign nf_below  = nf - BOT;
  assign nf_above  = ~(nf | nf_below);
  assign same_m    = going_up ? pu_q : pd_q;
  assign opp_m     = going_up ? pd_q : pu_q;
  assign ahead     = going_up ? |(req & nf_above) : |(req & nf_below);
  assign at_end    = going_up ? (nf == TOP) : (nf == BOT);
  assign hit_in    = |(pi_q & nf);
  assign hit_same  = |(same_m & nf);
  assign hit_opp   = |(opp_m & nf);
  assign stop      = hit_in | hit_same | (hit_opp & ~ahead) | at_end;
  assign trav_inc  = trav_q + 4'd1;
  assign dwell_inc = dwell_q + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      floor_q <= BOT;
      trav_q  <= '0;
      dwell_q <= '0;
      last_q  <= LD_NONE;
      pu_q    <= '0;
      pd_q    <= '0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      trav_q  <= trav_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
      pu_q    <= (pu_q | (btn_up & ~TOP))   & ~clr_up;
      pd_q    <= (pd_q | (btn_down & ~BOT)) & ~clr_dn;
      pi_q    <= (pi_q | btn_inside)        & ~clr_in;
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    trav_d  = trav_q;
    dwell_d = dwell_q;
    last_d  = last_q;
    clr_up  = '0;
    clr_dn  = '0;
    clr_in  = '0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          if (any_here) begin
            state_d = S_DOOR;
            dwell_d = '0;
            clr_up  = floor_q;
            clr_dn  = floor_q;
            clr_in  = floor_q;
          end else if (any_above && any_below) begin
            state_d = (last_q == LD_DOWN) ? S_DOWN : S_UP;
            trav_d  = '0;
          end else if (any_above) begin
            state_d = S_UP;
            trav_d  = '0;
          end else if (any_below) begin
            state_d = S_DOWN;
            trav_d  = '0;
          end
        end
      end
      S_UP, S_DOWN: begin
        if (tick) begin
          if (trav_inc == TRAV_LIM) begin
            floor_d = nf;
            trav_d  = '0;
            if (stop) begin
              state_d = S_DOOR;
              dwell_d = '0;
              last_d  = going_up ? LD_UP : LD_DOWN;
              clr_in  = nf;
              // Opposite-direction call is only answered once nothing lies ahead.
              if (going_up) begin
                clr_up = nf;
                if (!ahead) clr_dn = nf;
              end else begin
                clr_dn = nf;
                if (!ahead) clr_up = nf;
              end
            end
          end else begin
            trav_d = trav_inc;
          end
        end
      end
      S_DOOR: begin
        clr_up = pu_q & floor_q;
        clr_dn = pd_q & floor_q;
        clr_in = pi_q & floor_q;
        if (any_here) begin
          dwell_d = '0;
        end else if (tick) begin
          if (dwell_inc == DOOR_LIM) begin
            state_d = S_IDLE;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dir       = 2'b00;
    door_open = 1'b0;
    case (state_q)
      S_UP:    dir       = 2'b01;
      S_DOWN:  dir       = 2'b10;
      S_DOOR:  door_open = 1'b1;
      default: ;
    endcase
  end

  assign current_floor = floor_q;
  assign pend_up       = pu_q;
  assign pend_down     = pd_q;
  assign pend_inside   = pi_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: stimulus queues cycle-stamped expected
// output snapshots, a monitor compares them against the DUT on the falling edge.
module tb_elevator_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic [5:0] btn_up = '0, btn_down = '0, btn_inside = '0;
  logic [5:0] current_floor, pend_up, pend_down, pend_inside;
  logic [1:0] dir;
  logic       door_open;

  elevator_scheduler #(.FLOOR(6), .TRAVEL_TICKS(2), .DOOR_TICKS(3)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_inside(btn_inside),
    .current_floor(current_floor), .dir(dir), .door_open(door_open),
    .pend_up(pend_up), .pend_down(pend_down), .pend_inside(pend_inside)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Snapshot layout: {floor[26:21], dir[20:19], door[18], up[17:12], down[11:6], inside[5:0]}
  localparam logic [26:0] M_ALL = 27'h7ffffff;

  typedef struct {
    int          cyc;
    string       name;
    logic [26:0] exp;
    logic [26:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [26:0] mk(input logic [5:0] fl, input logic [1:0] d,
                                      input logic dr, input logic [5:0] pu,
                                      input logic [5:0] pd, input logic [5:0] pi);
    return {fl, d, dr, pu, pd, pi};
  endfunction

  // Monitor: compare every entry whose stamp has come due.
  initial begin
    exp_t        e;
    logic [26:0] act;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        act = {current_floor, dir, door_open, pend_up, pend_down, pend_inside};
        n_chk++;
        if (e.cyc != cyc || (act & e.mask) != (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got fl=%b dir=%b door=%b up=%b dn=%b in=%b, expected fl=%b dir=%b door=%b up=%b dn=%b in=%b (cycle %0d)",
                   e.name, act[26:21], act[20:19], act[18], act[17:12], act[11:6], act[5:0],
                   e.exp[26:21], e.exp[20:19], e.exp[18], e.exp[17:12], e.exp[11:6], e.exp[5:0], cyc);
        end
      end
    end
  end

  task automatic expect_next(input string nm, input logic [26:0] e, input logic [26:0] m);
    exp_t x;
    x.cyc  = cyc + 1;
    x.name = nm;
    x.exp  = e;
    x.mask = m;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [26:0] e);
    expect_next(nm, e, M_ALL);
    @(negedge clock);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic press(input logic [5:0] up, input logic [5:0] dn, input logic [5:0] in);
    btn_up = up; btn_down = dn; btn_inside = in;
    @(negedge clock);
    btn_up = '0; btn_down = '0; btn_inside = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    // Reset state while reset is held.
    @(negedge clock);
    expect_next("reset", mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0), M_ALL);
    @(negedge clock);
    reset = 1'b0;

    // Test 1: ten idle ticks with no buttons.
    for (int k = 0; k < 10; k++) begin
      tick_n(1);
      chk($sformatf("idle%0d", k), mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));
    end

    // Test 2: car call to floor 3.
    press(6'h0, 6'h0, 6'b000100);
    chk("t2_latch",  mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'b000100));
    tick_n(1);
    chk("t2_depart", mk(6'b000001, 2'b01, 1'b0, 6'h0, 6'h0, 6'b000100));
    tick_n(3);
    chk("t2_mid",    mk(6'b000010, 2'b01, 1'b0, 6'h0, 6'h0, 6'b000100));
    tick_n(1);
    chk("t2_arrive", mk(6'b000100, 2'b00, 1'b1, 6'h0, 6'h0, 6'h0));
    tick_n(2);
    chk("t2_dwell",  mk(6'b000100, 2'b00, 1'b1, 6'h0, 6'h0, 6'h0));
    tick_n(1);
    chk("t2_close",  mk(6'b000100, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));

    // Test 5: at floor 3, last direction up; calls above and below together.
    press(6'b010000, 6'h0, 6'b000001);
    chk("t5_latch",  mk(6'b000100, 2'b00, 1'b0, 6'b010000, 6'h0, 6'b000001));
    tick_n(1);
    chk("t5_up",     mk(6'b000100, 2'b01, 1'b0, 6'b010000, 6'h0, 6'b000001));
    tick_n(2);
    chk("t5_fl4",    mk(6'b001000, 2'b01, 1'b0, 6'b010000, 6'h0, 6'b000001));
    tick_n(2);
    chk("t5_fl5",    mk(6'b010000, 2'b00, 1'b1, 6'h0, 6'h0, 6'b000001));
    tick_n(3);
    chk("t5_close5", mk(6'b010000, 2'b00, 1'b0, 6'h0, 6'h0, 6'b000001));
    tick_n(1);
    chk("t5_down",   mk(6'b010000, 2'b10, 1'b0, 6'h0, 6'h0, 6'b000001));
    tick_n(7);
    chk("t5_fl2",    mk(6'b000010, 2'b10, 1'b0, 6'h0, 6'h0, 6'b000001));
    tick_n(1);
    chk("t5_fl1",    mk(6'b000001, 2'b00, 1'b1, 6'h0, 6'h0, 6'h0));
    tick_n(3);
    chk("t5_close1", mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));

    // Test 4: hall-up at the current floor opens the door on the next tick.
    press(6'b000001, 6'h0, 6'h0);
    chk("t4_latch",  mk(6'b000001, 2'b00, 1'b0, 6'b000001, 6'h0, 6'h0));
    tick_n(1);
    chk("t4_open",   mk(6'b000001, 2'b00, 1'b1, 6'h0, 6'h0, 6'h0));
    tick_n(3);
    chk("t4_close",  mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));
    // Top-floor up and bottom-floor down buttons do not exist.
    press(6'b100000, 6'b000001, 6'h0);
    chk("t4_masked", mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));
    tick_n(1);
    chk("t4_stay",   mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));

    // Test 3: pass a down call on the way up, serve it on the way back.
    press(6'h0, 6'b000100, 6'b100000);
    chk("t3_latch",  mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'b000100, 6'b100000));
    tick_n(1);
    chk("t3_up",     mk(6'b000001, 2'b01, 1'b0, 6'h0, 6'b000100, 6'b100000));
    tick_n(4);
    chk("t3_pass3",  mk(6'b000100, 2'b01, 1'b0, 6'h0, 6'b000100, 6'b100000));
    tick_n(6);
    chk("t3_top",    mk(6'b100000, 2'b00, 1'b1, 6'h0, 6'b000100, 6'h0));
    tick_n(3);
    chk("t3_close6", mk(6'b100000, 2'b00, 1'b0, 6'h0, 6'b000100, 6'h0));
    tick_n(1);
    chk("t3_down",   mk(6'b100000, 2'b10, 1'b0, 6'h0, 6'b000100, 6'h0));
    tick_n(6);
    chk("t3_fl3",    mk(6'b000100, 2'b00, 1'b1, 6'h0, 6'h0, 6'h0));
    tick_n(3);
    chk("t3_close3", mk(6'b000100, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));

    // Test 6: return to floor 1, then reset mid-move between floors 2 and 3.
    press(6'h0, 6'h0, 6'b000001);
    tick_n(8);
    chk("t6_home",   mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));
    press(6'h0, 6'h0, 6'b100000);
    tick_n(4);
    chk("t6_moving", mk(6'b000010, 2'b01, 1'b0, 6'h0, 6'h0, 6'b100000));
    reset = 1'b1;
    expect_next("t6_reset", mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0), M_ALL);
    @(negedge clock);
    reset = 1'b0;
    tick_n(4);
    chk("t6_after",  mk(6'b000001, 2'b00, 1'b0, 6'h0, 6'h0, 6'h0));

    repeat (3) @(negedge clock);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
